intr_request_gen: RTL and testbench

Peripheral-side interrupt requester for the core's two-line interrupt controller. It converts raw peripheral event signals into level interrupt requests (`intr_req`, wired to the controller's `intr_in`). It holds each request until the controller's registered acknowledge arrives, then runs a drop/re-arm handshake. Events that arrive while a request is outstanding are counted per source, so no event is lost up to the counter depth.

---
 rtl/intr_request_gen.sv | 106 ++++++++++
 tb/tb_intr_request_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_request_gen.sv
// Peripheral interrupt requester: event edges become level requests with a drop/re-arm ack handshake.
// Latency: event edge to intr_req is 1 cycle; queued events are counted per source and saturate with a sticky ovf flag.
module intr_request_gen #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       evt_in,
    input  logic [NUM_SRC-1:0]       src_en,
    input  logic [NUM_SRC-1:0]       intr_ack,
    input  logic [NUM_SRC-1:0]       ovf_clr,
    output logic [NUM_SRC-1:0]       intr_req,
    output logic [NUM_SRC*CNT_W-1:0] pend_cnt,
    output logic [NUM_SRC-1:0]       ovf,
    output logic [NUM_SRC-1:0]       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_SRC-1:0] evt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_in;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [1:0]       state;
        logic [1:0]       state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             ovf_r;
        logic             ovf_nxt;
        logic             evt_edge;
        logic             take;
        logic             sat_hit;

        always_comb begin
            evt_edge = evt_in[i] & ~evt_q[i] & src_en[i];
            take     = (state == ST_REQ) & intr_ack[i] & src_en[i];
            sat_hit  = evt_edge & ~take & (cnt == CNT_MAX);

            // An edge and an ack-take in the same cycle cancel out.
            cnt_nxt = cnt;
            if (!src_en[i]) begin
                cnt_nxt = '0;
            end else if (evt_edge && !take && cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_ONE;
            end else if (take && !evt_edge) begin
                cnt_nxt = cnt - CNT_ONE;
            end

            ovf_nxt = ovf_r;
            if (sat_hit) begin
                ovf_nxt = 1'b1;
            end else if (ovf_clr[i]) begin
                ovf_nxt = 1'b0;
            end

            state_nxt = state;
            case (state)
                ST_IDLE: begin
                    if (evt_edge || (cnt != '0 && src_en[i])) state_nxt = ST_REQ;
                end
                ST_REQ: begin
                    if (!src_en[i])  state_nxt = ST_IDLE;
                    else if (take)   state_nxt = ST_DROP;
                end
                ST_DROP: begin
                    // Re-arm only once the controller has released its ack.
                    if (!intr_ack[i]) begin
                        state_nxt = (cnt_nxt != '0 && src_en[i]) ? ST_REQ : ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state <= ST_IDLE;
                cnt   <= '0;
                ovf_r <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                ovf_r <= ovf_nxt;
            end
        end

        assign intr_req[i]                 = (state == ST_REQ);
        assign busy[i]                     = (state != ST_IDLE);
        assign ovf[i]                      = ovf_r;
        assign pend_cnt[i*CNT_W +: CNT_W]  = cnt;
    end

endmodule

// File: tb/tb_intr_request_gen.sv
// Scenario bench for intr_request_gen: expected request rises are queued and matched by a monitor.
module tb_intr_request_gen;

    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_SRC-1:0]       evt_in;
    logic [NUM_SRC-1:0]       src_en;
    logic [NUM_SRC-1:0]       intr_ack;
    logic [NUM_SRC-1:0]       ovf_clr;
    logic [NUM_SRC-1:0]       intr_req;
    logic [NUM_SRC*CNT_W-1:0] pend_cnt;
    logic [NUM_SRC-1:0]       ovf;
    logic [NUM_SRC-1:0]       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int src;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    intr_request_gen #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .evt_in   (evt_in),
        .src_en   (src_en),
        .intr_ack (intr_ack),
        .ovf_clr  (ovf_clr),
        .intr_req (intr_req),
        .pend_cnt (pend_cnt),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int get_cnt(int s);
        return int'(pend_cnt[s*CNT_W +: CNT_W]);
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_req(int s, int c);
        exp_t e;
        e.src = s;
        e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Every rising request must match the oldest queued expectation and respect the low gap.
    int cyc = 0;
    int last_fall[NUM_SRC] = '{-1, -1};
    logic [NUM_SRC-1:0] prev_req = '0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (intr_req[s] === 1'b1 && prev_req[s] !== 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: src %0d rose with cnt %0d, no request expected", s, get_cnt(s));
                end else begin
                    e = exp_q.pop_front();
                    if (e.src != s || e.cnt != get_cnt(s)) begin
                        errors++;
                        $display("FAIL req_scoreboard: got src %0d cnt %0d, expected src %0d cnt %0d", s, get_cnt(s), e.src, e.cnt);
                    end
                end
                if (last_fall[s] >= 0) begin
                    checks++;
                    if (cyc - last_fall[s] < 2) begin
                        errors++;
                        $display("FAIL req_gap: src %0d low for %0d cycles, expected >= 2", s, cyc - last_fall[s]);
                    end
                end
            end
            if (intr_req[s] !== 1'b1 && prev_req[s] === 1'b1) last_fall[s] = cyc;
        end
        prev_req = intr_req;
    end

    task automatic test_reset();
        reset = 1'b1; evt_in = '0; src_en = '0; intr_ack = '0; ovf_clr = '0;
        step(2);
        checks++; if (intr_req !== 2'b00) begin errors++; $display("FAIL reset_req: got %b expected 00", intr_req); end
        checks++; if (pend_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %h expected 00", pend_cnt); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b expected 00", ovf); end
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_single_event();
        src_en = 2'b11;
        evt_in[0] = 1'b1;
        expect_req(0, 1);
        step(1);
        checks++; if (intr_req[0] !== 1'b1) begin errors++; $display("FAIL single_req: got %b expected 1", intr_req[0]); end
        checks++; if (get_cnt(0) != 1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", get_cnt(0)); end
        intr_ack[0] = 1'b1;
        step(1);
        checks++; if (intr_req[0] !== 1'b0) begin errors++; $display("FAIL single_drop: got %b expected 0", intr_req[0]); end
        checks++; if (get_cnt(0) != 0) begin errors++; $display("FAIL single_cnt_dec: got %0d expected 0", get_cnt(0)); end
        step(1);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_drop_busy: got %b expected 1", busy[0]); end
        evt_in[0] = 1'b0;
        intr_ack[0] = 1'b0;
        step(1);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b expected 0", busy[0]); end
    endtask

    task automatic test_queued_events();
        expect_req(1, 1);
        for (int k = 0; k < 3; k++) begin
            evt_in[1] = 1'b1;
            step(1);
            evt_in[1] = 1'b0;
            step(1);
        end
        checks++; if (get_cnt(1) != 3) begin errors++; $display("FAIL queued_cnt: got %0d expected 3", get_cnt(1)); end
        for (int k = 0; k < 3; k++) begin
            intr_ack[1] = 1'b1;
            step(1);
            checks++; if (intr_req[1] !== 1'b0 || get_cnt(1) != 2 - k) begin
                errors++; $display("FAIL queued_take%0d: got req %b cnt %0d expected req 0 cnt %0d", k, intr_req[1], get_cnt(1), 2 - k);
            end
            step(1);
            intr_ack[1] = 1'b0;
            if (2 - k > 0) expect_req(1, 2 - k);
            step(1);
            checks++; if (intr_req[1] !== ((2 - k > 0) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL queued_rearm%0d: got %b expected %b", k, intr_req[1], (2 - k > 0));
            end
        end
        checks++; if (get_cnt(1) != 0 || busy[1] !== 1'b0) begin errors++; $display("FAIL queued_final: got cnt %0d busy %b expected 0 0", get_cnt(1), busy[1]); end
    endtask

    task automatic test_saturation();
        expect_req(0, 1);
        for (int j = 0; j < 17; j++) begin
            evt_in[0] = 1'b1;
            step(1);
            evt_in[0] = 1'b0;
            step(1);
            if (j == 14) begin
                checks++; if (get_cnt(0) != 15 || ovf[0] !== 1'b0) begin
                    errors++; $display("FAIL sat_at_max: got cnt %0d ovf %b expected 15 0", get_cnt(0), ovf[0]);
                end
            end
        end
        checks++; if (get_cnt(0) != 15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", get_cnt(0)); end
        checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", ovf[0]); end
        ovf_clr[0] = 1'b1;
        step(1);
        ovf_clr[0] = 1'b0;
        checks++; if (ovf[0] !== 1'b0 || get_cnt(0) != 15) begin errors++; $display("FAIL sat_ovf_clr: got ovf %b cnt %0d expected 0 15", ovf[0], get_cnt(0)); end
        evt_in[0] = 1'b1;
        ovf_clr[0] = 1'b1;
        step(1);
        evt_in[0] = 1'b0;
        ovf_clr[0] = 1'b0;
        checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b expected 1", ovf[0]); end
        src_en[0] = 1'b0;
        step(1);
        checks++; if (get_cnt(0) != 0 || busy[0] !== 1'b0 || intr_req[0] !== 1'b0) begin
            errors++; $display("FAIL sat_disable: got cnt %0d busy %b req %b expected 0 0 0", get_cnt(0), busy[0], intr_req[0]);
        end
        src_en[0] = 1'b1;
        step(1);
    endtask

    task automatic test_simultaneous();
        evt_in[1] = 1'b1;
        expect_req(1, 1);
        step(1);
        evt_in[1] = 1'b0;
        step(1);
        intr_ack[1] = 1'b1;
        evt_in[1] = 1'b1;
        step(1);
        evt_in[1] = 1'b0;
        checks++; if (get_cnt(1) != 1 || intr_req[1] !== 1'b0) begin
            errors++; $display("FAIL simul_cnt: got cnt %0d req %b expected 1 0", get_cnt(1), intr_req[1]);
        end
        step(1);
        intr_ack[1] = 1'b0;
        expect_req(1, 1);
        step(1);
        checks++; if (intr_req[1] !== 1'b1) begin errors++; $display("FAIL simul_rearm: got %b expected 1", intr_req[1]); end
        intr_ack[1] = 1'b1;
        step(2);
        intr_ack[1] = 1'b0;
        step(1);
        checks++; if (get_cnt(1) != 0 || busy[1] !== 1'b0) begin errors++; $display("FAIL simul_final: got cnt %0d busy %b expected 0 0", get_cnt(1), busy[1]); end
    endtask

    task automatic test_disable_spurious();
        expect_req(0, 1);
        evt_in[0] = 1'b1;
        step(1);
        evt_in[0] = 1'b0;
        step(1);
        evt_in[0] = 1'b1;
        step(1);
        evt_in[0] = 1'b0;
        checks++; if (get_cnt(0) != 2 || intr_req[0] !== 1'b1) begin
            errors++; $display("FAIL dis_setup: got cnt %0d req %b expected 2 1", get_cnt(0), intr_req[0]);
        end
        src_en[0] = 1'b0;
        step(1);
        checks++; if (intr_req[0] !== 1'b0 || get_cnt(0) != 0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL dis_in_req: got req %b cnt %0d busy %b expected 0 0 0", intr_req[0], get_cnt(0), busy[0]);
        end
        for (int k = 0; k < 2; k++) begin
            evt_in[0] = 1'b1;
            step(1);
            evt_in[0] = 1'b0;
            step(1);
        end
        checks++; if (get_cnt(0) != 0 || busy[0] !== 1'b0) begin errors++; $display("FAIL dis_edges: got cnt %0d busy %b expected 0 0", get_cnt(0), busy[0]); end
        src_en[0] = 1'b1;
        intr_ack[0] = 1'b1;
        step(2);
        intr_ack[0] = 1'b0;
        checks++; if (busy[0] !== 1'b0 || intr_req[0] !== 1'b0) begin
            errors++; $display("FAIL spurious_ack: got busy %b req %b expected 0 0", busy[0], intr_req[0]);
        end
    endtask

    task automatic test_reset_mid_handshake();
        expect_req(1, 1);
        for (int k = 0; k < 3; k++) begin
            evt_in[1] = 1'b1;
            step(1);
            evt_in[1] = 1'b0;
            step(1);
        end
        intr_ack[1] = 1'b1;
        step(1);
        checks++; if (get_cnt(1) != 2 || busy[1] !== 1'b1 || intr_req[1] !== 1'b0) begin
            errors++; $display("FAIL rst_setup: got cnt %0d busy %b req %b expected 2 1 0", get_cnt(1), busy[1], intr_req[1]);
        end
        reset = 1'b1;
        step(1);
        checks++; if (intr_req !== 2'b00 || pend_cnt !== '0 || ovf !== 2'b00 || busy !== 2'b00) begin
            errors++; $display("FAIL rst_mid: got req %b cnt %h ovf %b busy %b expected all 0", intr_req, pend_cnt, ovf, busy);
        end
        reset = 1'b0;
        intr_ack[1] = 1'b0;
        step(6);
        checks++; if (intr_req !== 2'b00 || busy !== 2'b00) begin
            errors++; $display("FAIL rst_no_rereq: got req %b busy %b expected 00 00", intr_req, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_queued_events();
        test_saturation();
        test_simultaneous();
        test_disable_spurious();
        test_reset_mid_handshake();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected requests, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
